frame_mem_responder: RTL and testbench

Memory-side responder for the frame-format requester. It accepts single-word requests (req, rd_wr, row, col, tem_win) and maps row/col to a physical SRAM address in either the template or the window region. It drives a fixed-latency synchronous SRAM and returns read data with a one-cycle valid strobe. It also counts completed frames from set_done pulses.

---
 rtl/frame_mem_pkg.sv | 10 +
 rtl/frame_addr_map.sv | 15 +
 rtl/frame_mem_responder.sv | 151 +++++++++++++++
 tb/tb_frame_mem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_mem_pkg.sv
// frame_mem_pkg: shared state encoding, field widths and default region bases for the frame memory responder
package frame_mem_pkg;
  localparam int DATA_W      = 32;
  localparam int ROW_W       = 7;
  localparam int COL_W       = 7;
  localparam int FRAME_CNT_W = 8;
  localparam logic [15:0] TEMPLATE_BASE_DEF = 16'h0000;
  localparam logic [15:0] WINDOW_BASE_DEF   = 16'h4000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/frame_addr_map.sv
// frame_addr_map: region select plus base+{row,col}, truncated to ADDR_W (wraps silently)
module frame_addr_map
  import frame_mem_pkg::*;
#(
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] TEMPLATE_BASE = ADDR_W'(TEMPLATE_BASE_DEF),
  parameter logic [ADDR_W-1:0] WINDOW_BASE   = ADDR_W'(WINDOW_BASE_DEF)
) (
  input  logic             tem_win,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output logic [ADDR_W-1:0] addr
);
  assign addr = (tem_win ? WINDOW_BASE : TEMPLATE_BASE) + ADDR_W'({row, col});
endmodule

// File: rtl/frame_mem_responder.sv
// frame_mem_responder: single-word request to fixed-latency SRAM bridge with frame counter.
// Optional FRAME_MEM_TEMPLATE_WP_EN makes the template region read-only and adds an err output.
module frame_mem_responder
  import frame_mem_pkg::*;
#(
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] TEMPLATE_BASE = ADDR_W'(TEMPLATE_BASE_DEF),
  parameter logic [ADDR_W-1:0] WINDOW_BASE   = ADDR_W'(WINDOW_BASE_DEF),
  parameter int                RD_LAT        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   rd_wr,
  input  logic [DATA_W-1:0]      write_data,
  input  logic [ROW_W-1:0]       row,
  input  logic [COL_W-1:0]       col,
  input  logic                   tem_win,
  input  logic                   set_done,
  output logic                   ack,
  output logic                   data_valid,
  output logic [DATA_W-1:0]      read_data,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
`ifdef FRAME_MEM_TEMPLATE_WP_EN
  ,
  output logic                   err
`endif
);
  state_t                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     wr_q, wr_d;
  logic                     ack_q, ack_d, dv_q, dv_d, busy_q, busy_d, en_q, en_d, we_q, we_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]        addr_q, addr_d, map_addr;
  logic [FRAME_CNT_W-1:0]   fc_q, fc_d;
  logic                     blk;
  logic                     err_q, err_d;

  frame_addr_map #(
    .ADDR_W       (ADDR_W),
    .TEMPLATE_BASE(TEMPLATE_BASE),
    .WINDOW_BASE  (WINDOW_BASE)
  ) u_map (
    .tem_win(tem_win),
    .row    (row),
    .col    (col),
    .addr   (map_addr)
  );

  // A blocked template write is still acked, but never reaches the SRAM
`ifdef FRAME_MEM_TEMPLATE_WP_EN
  assign blk = rd_wr & ~tem_win;
  assign err = err_q;
`else
  assign blk = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    dv_d    = 1'b0;
    en_d    = 1'b0;
    we_d    = 1'b0;
    err_d   = 1'b0;
    fc_d    = fc_q + FRAME_CNT_W'(set_done);
    case (state_q)
      IDLE: if (req) begin
        state_d = ISSUE;
        wr_d    = rd_wr;
        addr_d  = map_addr;
        wdata_d = write_data;
        ack_d   = 1'b1;
        en_d    = ~blk;
        we_d    = rd_wr & ~blk;
        err_d   = blk;
      end
      ISSUE: begin
        state_d = wr_q ? IDLE : (RD_LAT == 1 ? RESP : WAIT);
        cnt_d   = 3'(RD_LAT - 2);
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = cnt_q == 3'd0 ? RESP : WAIT;
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = mem_rdata;
        dv_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      we_q    <= we_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
    end
  end

  assign ack         = ack_q;
  assign data_valid  = dv_q;
  assign read_data   = rdata_q;
  assign busy        = busy_q;
  assign frame_count = fc_q;
  assign mem_en      = en_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
`ifndef FRAME_MEM_TEMPLATE_WP_EN
  logic unused_err;
  assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_frame_mem_responder.sv
// tb_frame_mem_responder: directed stimulus with ack/read scoreboards checked by a negedge monitor
module tb_frame_mem_responder;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wd;
  } ack_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, rd_wr = 1'b0, tem_win = 1'b0, set_done = 1'b0;
  logic [31:0] write_data = '0;
  logic [6:0]  row = '0, col = '0;
  logic        ack, data_valid, busy, mem_en, mem_we;
  logic [31:0] read_data, mem_wdata, mem_rdata;
  logic [7:0]  frame_count;
  logic [15:0] mem_addr;
`ifdef FRAME_MEM_TEMPLATE_WP_EN
  logic        err;
`endif

  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [0:65535];
  logic [31:0] pipe [RD_LAT];

  int   checks = 0, errors = 0;
  ack_t        exp_ack[$];
  logic [31:0] exp_rd[$];

  always #5 clk = ~clk;

  frame_mem_responder #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rd_wr(rd_wr), .write_data(write_data),
    .row(row), .col(col), .tem_win(tem_win), .set_done(set_done),
    .ack(ack), .data_valid(data_valid), .read_data(read_data), .busy(busy),
    .frame_count(frame_count), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef FRAME_MEM_TEMPLATE_WP_EN
    , .err(err)
`endif
  );

  // SRAM model: data appears RD_LAT cycles after the mem_en cycle, filler otherwise
  always @(posedge clk) begin
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 32'hBAD0BAD0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = pipe[RD_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack) begin
      if (exp_ack.size() == 0) check("unexpected ack", 1, 0);
      else begin
        ack_t e;
        e = exp_ack.pop_front();
        check("ack mem_en", mem_en, e.en);
        check("ack mem_we", mem_we, e.we);
        check("ack mem_addr", mem_addr, e.addr);
        if (e.we) check("ack mem_wdata", mem_wdata, e.wd);
      end
    end
    if (data_valid) begin
      if (exp_rd.size() == 0) check("unexpected data_valid", 1, 0);
      else check("read_data", read_data, exp_rd.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1 pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1 pre_en = 1'b0;
  endtask

  task automatic req_op(input logic rw, input logic tw, input logic [6:0] r, input logic [6:0] c,
                        input logic [31:0] wd, input logic [15:0] addr, input logic en,
                        input logic push_rd, input logic [31:0] rd);
    exp_ack.push_back('{en, rw & en, addr, wd});
    if (push_rd) exp_rd.push_back(rd);
    @(posedge clk); #1 req = 1'b1; rd_wr = rw; tem_win = tw; row = r; col = c; write_data = wd;
    @(posedge clk); #1 req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    check("rst ack", ack, 0);
    check("rst data_valid", data_valid, 0);
    check("rst busy", busy, 0);
    check("rst mem_en", mem_en, 0);
    check("rst mem_we", mem_we, 0);
    check("rst read_data", read_data, 0);
    check("rst frame_count", frame_count, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
`ifdef FRAME_MEM_TEMPLATE_WP_EN
    check("rst err", err, 0);
`endif
    rst_n = 1'b1;
    preload(16'h0105, 32'hDEADBEEF);
    preload(16'h4003, 32'hA5A50003);

    // template read, cycle-accurate
    req_op(0, 0, 7'd2, 7'd5, 0, 16'h0105, 1, 1, 32'hDEADBEEF);
    @(negedge clk);
    check("c1 ack", ack, 1); check("c1 busy", busy, 1); check("c1 mem_addr", mem_addr, 16'h0105);
    @(negedge clk);
    check("c2 ack", ack, 0); check("c2 mem_en", mem_en, 0);
    @(negedge clk);
    check("c3 data_valid", data_valid, 0);
    @(negedge clk);
    check("c4 data_valid", data_valid, 1); check("c4 busy", busy, 0);
    @(negedge clk);
    check("c5 data_valid", data_valid, 0); check("c5 read_data hold", read_data, 32'hDEADBEEF);

    // window write to the top corner, then read it back
    req_op(1, 1, 7'd127, 7'd127, 32'h12345678, 16'h7FFF, 1, 0, 0);
    @(negedge clk);
    check("wr mem_we", mem_we, 1); check("wr mem_addr", mem_addr, 16'h7FFF);
    @(negedge clk);
    check("wr c2 busy", busy, 0);
    req_op(0, 1, 7'd127, 7'd127, 0, 16'h7FFF, 1, 1, 32'h12345678);
    cyc(5);

    // requests while busy are dropped
    req_op(0, 1, 7'd0, 7'd3, 0, 16'h4003, 1, 1, 32'hA5A50003);
    cyc(1); req = 1'b1; rd_wr = 1'b1; tem_win = 1'b0; row = 7'd5; col = 7'd5;
    cyc(1); req = 1'b0;
    cyc(1);
    cyc(1);
    exp_ack.push_back('{1'b1, 1'b0, 16'h0105, 32'h0});
    exp_rd.push_back(32'hDEADBEEF);
    req = 1'b1; rd_wr = 1'b0; tem_win = 1'b0; row = 7'd2; col = 7'd5;
    @(negedge clk);
    check("c5 no ack", ack, 0);
    cyc(1); req = 1'b0;
    @(negedge clk);
    check("c6 held req ack", ack, 1);
    cyc(5);

    // frame counter wrap with concurrent reads
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          @(posedge clk); #1 set_done = 1'b1;
          if (i == 200) begin
            @(negedge clk);
            check("frame_count mid", frame_count, 200);
          end
        end
        @(posedge clk); #1 set_done = 1'b0;
      end
      begin
        req_op(0, 0, 7'd2, 7'd5, 0, 16'h0105, 1, 1, 32'hDEADBEEF);
        cyc(6);
        req_op(0, 1, 7'd127, 7'd127, 0, 16'h7FFF, 1, 1, 32'h12345678);
        cyc(6);
      end
    join
    @(negedge clk);
    check("frame_count wrap", frame_count, 0);

    // reset while waiting on the SRAM drops the read
    req_op(0, 0, 7'd2, 7'd5, 0, 16'h0105, 1, 0, 0);
    cyc(1); rst_n = 1'b0;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst read_data", read_data, 0);
    check("mid rst mem_addr", mem_addr, 0);
    check("mid rst data_valid", data_valid, 0);
    cyc(2); rst_n = 1'b1;
    cyc(6);
    @(negedge clk);
    check("post rst busy", busy, 0);

`ifdef FRAME_MEM_TEMPLATE_WP_EN
    // template write is blocked but acked, with err
    req_op(1, 0, 7'd2, 7'd5, 32'hCAFEF00D, 16'h0105, 0, 0, 0);
    @(negedge clk);
    check("wp ack", ack, 1); check("wp err", err, 1); check("wp mem_we", mem_we, 0);
    req_op(0, 0, 7'd2, 7'd5, 0, 16'h0105, 1, 1, 32'hDEADBEEF);
`else
    // template write proceeds normally
    req_op(1, 0, 7'd0, 7'd1, 32'hCAFEF00D, 16'h0001, 1, 0, 0);
    @(negedge clk);
    check("tmpl wr mem_we", mem_we, 1);
    req_op(0, 0, 7'd0, 7'd1, 0, 16'h0001, 1, 1, 32'hCAFEF00D);
`endif
    cyc(6);
    check("ack queue drained", exp_ack.size(), 0);
    check("read queue drained", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
